// File: rtl/tetris_pkg.sv
// Shared types and helpers for the tetromino spin controller.
package tetris_pkg;

  localparam int unsigned XSIZE     = 3;
  localparam int unsigned YSIZE     = 3;
  localparam int unsigned NUM_CELLS = 4;

  // Coordinates carry one extra bit so underflow/overflow show up in the MSB.
  typedef logic [XSIZE:0] coord_x_t;
  typedef logic [YSIZE:0] coord_y_t;

  typedef logic [1:0] spin_t;

  typedef enum logic [2:0] {
    StIdle,
    StCalc,
    StCheck,
    StDone,
    StKick
  } spin_state_e;

  // Linear board bit index of cell (x, y).
  function automatic int unsigned board_index(input int unsigned x, input int unsigned y,
                                              input int unsigned xsize);
    return y * (32'd1 << xsize) + x;
  endfunction

endpackage

// File: rtl/cell_bounds_check.sv
// Single-cell legality test: out of bounds (MSB set) or landing on an occupied bit.
module cell_bounds_check
  import tetris_pkg::*;
#(
  parameter int unsigned XSIZE = 3,
  parameter int unsigned YSIZE = 3
) (
  input  logic [XSIZE:0]                        cx,
  input  logic [YSIZE:0]                        cy,
  input  logic [(2**XSIZE)*(2**YSIZE)-1:0]      board,
  output logic                                  fail
);

  logic [XSIZE+YSIZE-1:0] idx;

  // Index uses only the in-range bits; the MSB test covers the rest.
  always_comb begin
    idx  = (XSIZE + YSIZE)'(board_index(32'(cx[XSIZE-1:0]), 32'(cy[YSIZE-1:0]), XSIZE));
    fail = cx[XSIZE] | cy[YSIZE] | board[idx];
  end

endmodule

// File: rtl/piece_spinner.sv
// Rotated candidate: each cell moves by its table offset; spin state advances by one.
module piece_spinner
  import tetris_pkg::*;
#(
  parameter int unsigned XSIZE = 3,
  parameter int unsigned YSIZE = 3
) (
  input  logic [3:0][XSIZE:0] cur_x,
  input  logic [3:0][YSIZE:0] cur_y,
  input  logic [3:0][XSIZE:0] spin_x,
  input  logic [3:0][YSIZE:0] spin_y,
  input  spin_t               cur_spin,
  output logic [3:0][XSIZE:0] cand_x,
  output logic [3:0][YSIZE:0] cand_y,
  output spin_t               new_spin
);

  // Two's-complement add, wrapping at the coordinate width.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cand_x[i] = cur_x[i] + spin_x[i];
      cand_y[i] = cur_y[i] + spin_y[i];
    end
    new_spin = cur_spin + 2'd1;
  end

endmodule

// File: rtl/spin_controller.sv
// Tetromino rotation sequencer: compute candidate, check cells one per cycle, commit or reject.
// Optional wall kick (retry at x+1, then x-1) enabled by defining SPIN_WALL_KICK_EN.
module spin_controller
  import tetris_pkg::*;
#(
  parameter int unsigned XSIZE = 3,
  parameter int unsigned YSIZE = 3
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               load,
  input  logic [3:0][XSIZE:0]                load_x,
  input  logic [3:0][YSIZE:0]                load_y,
  input  spin_t                              load_spin,
  input  logic                               spin_req,
  input  logic [3:0][XSIZE:0]                spin_x,
  input  logic [3:0][YSIZE:0]                spin_y,
  input  logic [(2**XSIZE)*(2**YSIZE)-1:0]   board,
  output logic [3:0][XSIZE:0]                cur_x,
  output logic [3:0][YSIZE:0]                cur_y,
  output spin_t                              cur_spin,
  output logic                               busy,
  output logic                               done,
  output logic                               spin_ok
);

  spin_state_e         state_q, state_d;
  logic [1:0]          cell_q, cell_d;
  logic [3:0][XSIZE:0] cur_x_q, cur_x_d, cand_x_q, cand_x_d, sp_x;
  logic [3:0][YSIZE:0] cur_y_q, cur_y_d, cand_y_q, cand_y_d, sp_y;
  spin_t               cur_spin_q, cur_spin_d, new_spin_q, new_spin_d, sp_spin;
  logic                spin_ok_q, spin_ok_d;
  logic                cell_fail;
`ifdef SPIN_WALL_KICK_EN
  logic [1:0]          kick_q, kick_d;
  logic [XSIZE:0]      kick_delta;
`endif

  piece_spinner #(
    .XSIZE(XSIZE),
    .YSIZE(YSIZE)
  ) u_spinner (
    .cur_x   (cur_x_q),
    .cur_y   (cur_y_q),
    .spin_x  (spin_x),
    .spin_y  (spin_y),
    .cur_spin(cur_spin_q),
    .cand_x  (sp_x),
    .cand_y  (sp_y),
    .new_spin(sp_spin)
  );

  cell_bounds_check #(
    .XSIZE(XSIZE),
    .YSIZE(YSIZE)
  ) u_check (
    .cx   (cand_x_q[cell_q]),
    .cy   (cand_y_q[cell_q]),
    .board(board),
    .fail (cell_fail)
  );

  // Next-state logic; load overrides everything except reset.
  always_comb begin
    state_d    = state_q;
    cell_d     = cell_q;
    cur_x_d    = cur_x_q;
    cur_y_d    = cur_y_q;
    cur_spin_d = cur_spin_q;
    cand_x_d   = cand_x_q;
    cand_y_d   = cand_y_q;
    new_spin_d = new_spin_q;
    spin_ok_d  = spin_ok_q;
`ifdef SPIN_WALL_KICK_EN
    kick_d     = kick_q;
    kick_delta = (kick_q == 2'd0) ? (XSIZE + 1)'(1) : (XSIZE + 1)'(-2);
`endif
    if (load) begin
      cur_x_d    = load_x;
      cur_y_d    = load_y;
      cur_spin_d = load_spin;
      state_d    = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (spin_req) state_d = StCalc;
        end
        StCalc: begin
          cand_x_d   = sp_x;
          cand_y_d   = sp_y;
          new_spin_d = sp_spin;
          cell_d     = 2'd0;
`ifdef SPIN_WALL_KICK_EN
          kick_d     = 2'd0;
`endif
          state_d    = StCheck;
        end
        StCheck: begin
          if (cell_fail) begin
`ifdef SPIN_WALL_KICK_EN
            if (kick_q < 2'd2) begin
              state_d = StKick;
            end else begin
              spin_ok_d = 1'b0;
              state_d   = StDone;
            end
`else
            spin_ok_d = 1'b0;
            state_d   = StDone;
`endif
          end else if (cell_q == 2'd3) begin
            spin_ok_d  = 1'b1;
            cur_x_d    = cand_x_q;
            cur_y_d    = cand_y_q;
            cur_spin_d = new_spin_q;
            state_d    = StDone;
          end else begin
            cell_d = cell_q + 2'd1;
          end
        end
        StDone: begin
          state_d = StIdle;
        end
        StKick: begin
`ifdef SPIN_WALL_KICK_EN
          // First kick shifts +1, second shifts -2 (net -1 from the original candidate).
          for (int i = 0; i < 4; i++) cand_x_d[i] = cand_x_q[i] + kick_delta;
          kick_d  = kick_q + 2'd1;
          cell_d  = 2'd0;
          state_d = StCheck;
`else
          state_d = StIdle;
`endif
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cell_q     <= 2'd0;
      cur_x_q    <= '0;
      cur_y_q    <= '0;
      cur_spin_q <= '0;
      cand_x_q   <= '0;
      cand_y_q   <= '0;
      new_spin_q <= '0;
      spin_ok_q  <= 1'b0;
`ifdef SPIN_WALL_KICK_EN
      kick_q     <= 2'd0;
`endif
    end else begin
      state_q    <= state_d;
      cell_q     <= cell_d;
      cur_x_q    <= cur_x_d;
      cur_y_q    <= cur_y_d;
      cur_spin_q <= cur_spin_d;
      cand_x_q   <= cand_x_d;
      cand_y_q   <= cand_y_d;
      new_spin_q <= new_spin_d;
      spin_ok_q  <= spin_ok_d;
`ifdef SPIN_WALL_KICK_EN
      kick_q     <= kick_d;
`endif
    end
  end

  // Outputs decoded from registered state.
  always_comb begin
    cur_x    = cur_x_q;
    cur_y    = cur_y_q;
    cur_spin = cur_spin_q;
    busy     = (state_q != StIdle);
    done     = (state_q == StDone);
    spin_ok  = spin_ok_q;
  end

endmodule

// File: tb/tb_spin_controller.sv
// Directed bench for spin_controller: success, collision, bounds, load abort, kick, reset.
module tb_spin_controller;
  import tetris_pkg::*;

  logic             clk = 1'b0;
  logic             reset, load, spin_req;
  logic [3:0][3:0]  load_x, load_y, spin_x, spin_y, cur_x, cur_y;
  logic [1:0]       load_spin, cur_spin;
  logic [63:0]      board;
  logic             busy, done, spin_ok;

  int checks   = 0;
  int failures = 0;

  spin_controller #(
    .XSIZE(3),
    .YSIZE(3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_x   (load_x),
    .load_y   (load_y),
    .load_spin(load_spin),
    .spin_req (spin_req),
    .spin_x   (spin_x),
    .spin_y   (spin_y),
    .board    (board),
    .cur_x    (cur_x),
    .cur_y    (cur_y),
    .cur_spin (cur_spin),
    .busy     (busy),
    .done     (done),
    .spin_ok  (spin_ok)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0][3:0] cells(input int c0, input int c1, input int c2,
                                            input int c3);
    logic [3:0][3:0] r;
    r[0] = 4'(c0);
    r[1] = 4'(c1);
    r[2] = 4'(c2);
    r[3] = 4'(c3);
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [3:0][3:0] x, input logic [3:0][3:0] y,
                         input logic [1:0] s);
    load_x    = x;
    load_y    = y;
    load_spin = s;
    load      = 1'b1;
    tick();
    load      = 1'b0;
  endtask

  // Issue a request at E0 and find the edge after which done is high.
  task automatic run_spin(input string tag, input int exp_edge, input logic exp_ok);
    int   seen = 0;
    logic ok   = 1'b0;
    spin_req = 1'b1;
    tick();
    spin_req = 1'b0;
    check({tag, "_busy"}, 64'(busy), 64'd1);
    for (int e = 1; e <= 15; e++) begin
      tick();
      if (done) begin
        seen = e;
        ok   = spin_ok;
        break;
      end
    end
    check({tag, "_done_edge"}, 64'(seen), 64'(exp_edge));
    check({tag, "_spin_ok"}, 64'(ok), 64'(exp_ok));
    tick();
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    check({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int done_cnt;
    reset    = 1'b1;
    load     = 1'b0;
    spin_req = 1'b0;
    load_x   = '0;
    load_y   = '0;
    load_spin = '0;
    board    = '0;
    spin_x   = cells(2, 1, 0, -1);
    spin_y   = cells(-1, 0, 1, 2);
    tick();
    tick();
    reset = 1'b0;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_ok", 64'(spin_ok), 64'd0);
    check("rst_cur_x", 64'(cur_x), 64'd0);
    check("rst_cur_y", 64'(cur_y), 64'd0);
    check("rst_spin", 64'(cur_spin), 64'd0);

    // Success: candidate x={4,4,4,4} y={2,3,4,5}, done after E5.
    do_load(cells(2, 3, 4, 5), cells(3, 3, 3, 3), 2'd0);
    check("load_cur_x", 64'(cur_x), 64'(cells(2, 3, 4, 5)));
    check("load_busy", 64'(busy), 64'd0);
    run_spin("ok", 5, 1'b1);
    check("ok_cur_x", 64'(cur_x), 64'(cells(4, 4, 4, 4)));
    check("ok_cur_y", 64'(cur_y), 64'(cells(2, 3, 4, 5)));
    check("ok_spin", 64'(cur_spin), 64'd1);

    // Collision at (4,4) = cell 2, done after E4, no change.
    do_load(cells(2, 3, 4, 5), cells(3, 3, 3, 3), 2'd0);
    board = 64'd1 << (4 * 8 + 4);
    run_spin("col", 4, 1'b0);
    check("col_cur_x", 64'(cur_x), 64'(cells(2, 3, 4, 5)));
    check("col_cur_y", 64'(cur_y), 64'(cells(3, 3, 3, 3)));
    check("col_spin", 64'(cur_spin), 64'd0);
    board = '0;

    // Bounds: y = 0 + {-1,0,1,2} puts cell 0 at y=-1, so it fails on the first cell (E2).
    do_load(cells(0, 1, 2, 3), cells(0, 0, 0, 0), 2'd1);
    run_spin("oob", 2, 1'b0);
    check("oob_cur_y", 64'(cur_y), 64'(cells(0, 0, 0, 0)));
    check("oob_spin", 64'(cur_spin), 64'd1);

    // Load abort at E2 while checking.
    do_load(cells(2, 3, 4, 5), cells(3, 3, 3, 3), 2'd0);
    spin_req = 1'b1;
    tick();
    spin_req = 1'b0;
    tick();
    check("abort_busy_e1", 64'(busy), 64'd1);
    do_load(cells(1, 1, 1, 1), cells(0, 1, 2, 3), 2'd2);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_cur_x", 64'(cur_x), 64'(cells(1, 1, 1, 1)));
    check("abort_cur_y", 64'(cur_y), 64'(cells(0, 1, 2, 3)));
    check("abort_spin", 64'(cur_spin), 64'd2);
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) done_cnt++;
      tick();
    end
    check("abort_no_done", 64'(done_cnt), 64'd0);

    // Load and request together: load only.
    spin_req = 1'b1;
    do_load(cells(5, 5, 5, 5), cells(1, 2, 3, 4), 2'd3);
    spin_req = 1'b0;
    check("both_busy", 64'(busy), 64'd0);
    check("both_cur_x", 64'(cur_x), 64'(cells(5, 5, 5, 5)));
    tick();
    check("both_busy2", 64'(busy), 64'd0);
    check("both_done", 64'(done), 64'd0);

    // Wall kick: candidate x=6, (6,5) blocked at cell 2; x=7 column is free.
    do_load(cells(4, 5, 6, 7), cells(4, 4, 4, 4), 2'd0);
    board = 64'd1 << (5 * 8 + 6);
`ifdef SPIN_WALL_KICK_EN
    run_spin("kick", 9, 1'b1);
    check("kick_cur_x", 64'(cur_x), 64'(cells(7, 7, 7, 7)));
    check("kick_cur_y", 64'(cur_y), 64'(cells(3, 4, 5, 6)));
    check("kick_spin", 64'(cur_spin), 64'd1);
`else
    run_spin("kick", 4, 1'b0);
    check("kick_cur_x", 64'(cur_x), 64'(cells(4, 5, 6, 7)));
    check("kick_cur_y", 64'(cur_y), 64'(cells(4, 4, 4, 4)));
    check("kick_spin", 64'(cur_spin), 64'd0);
`endif
    board = '0;

    // Reset while checking.
    do_load(cells(2, 3, 4, 5), cells(3, 3, 3, 3), 2'd2);
    spin_req = 1'b1;
    tick();
    spin_req = 1'b0;
    tick();
    tick();
    check("mid_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_done", 64'(done), 64'd0);
    check("mrst_cur_x", 64'(cur_x), 64'd0);
    check("mrst_cur_y", 64'(cur_y), 64'd0);
    check("mrst_spin", 64'(cur_spin), 64'd0);
    tick();
    check("mrst_done2", 64'(done), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
